light_phase_sequencer: RTL and testbench

- Parametrised successor to the single-phase light countdown.
- Sequences N light phases (e.g. NS-green, NS-yellow, EW-green, EW-yellow) in a fixed cyclic order.
- Each phase has a runtime-programmable duration in seconds, counted on the 1 Hz sec_tick.
- Sits between the second-tick prescaler and the lamp decoder. Provides phase index, remaining count, and phase/cycle event pulses.

---
 rtl/light_pkg.sv | 21 ++
 rtl/light_dur_regfile.sv | 58 +++++
 rtl/light_phase_sequencer.sv | 152 +++++++++++++++
 tb/tb_light_phase_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the light phase sequencer: phase index type,
// the conventional four-phase intersection layout and its default timings.
package light_pkg;

  localparam int LP_STD_NUM_PHASES = 4;

  typedef logic [1:0] phase_idx_t;

  // Standard four-phase intersection ordering.
  localparam phase_idx_t PH_NS_GREEN  = 2'd0;
  localparam phase_idx_t PH_NS_YELLOW = 2'd1;
  localparam phase_idx_t PH_EW_GREEN  = 2'd2;
  localparam phase_idx_t PH_EW_YELLOW = 2'd3;

  // Typical durations in seconds for the standard phases.
  localparam logic [7:0] DUR_NS_GREEN  = 8'd15;
  localparam logic [7:0] DUR_NS_YELLOW = 8'd3;
  localparam logic [7:0] DUR_EW_GREEN  = 8'd15;
  localparam logic [7:0] DUR_EW_YELLOW = 8'd3;

endpackage

// File: rtl/light_dur_regfile.sv
// Per-phase duration storage. One write port with range check, one
// combinational read port that forwards a same-cycle write to the same
// phase so a load never sees a stale duration.
module light_dur_regfile
  import light_pkg::*;
#(
  parameter int P_NUM_PHASES = 4,
  parameter int P_CNT_W      = 8,
  parameter int P_DEF_DUR    = 15,
  parameter int P_IDX_W      = $clog2(P_NUM_PHASES)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               we,
  input  logic [P_IDX_W-1:0] waddr,
  input  logic [P_CNT_W-1:0] wdata,
  input  logic [P_IDX_W-1:0] raddr,
  output logic [P_CNT_W-1:0] rdata,
  output logic               wr_err
);

  localparam logic [P_IDX_W:0]   LP_NUM = P_NUM_PHASES[P_IDX_W:0];
  localparam logic [P_CNT_W-1:0] LP_DEF = P_CNT_W'(P_DEF_DUR);

  logic [P_CNT_W-1:0] dur_r [P_NUM_PHASES];
  logic               waddr_ok_s;
  logic               raddr_ok_s;

  // Address range checks for both ports.
  always_comb begin
    waddr_ok_s = ({1'b0, waddr} < LP_NUM);
    raddr_ok_s = ({1'b0, raddr} < LP_NUM);
    wr_err     = we & ~waddr_ok_s;
  end

  // Duration registers: default on reset, updated by in-range writes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < P_NUM_PHASES; i++) begin
        dur_r[i] <= LP_DEF;
      end
    end else if (we && waddr_ok_s) begin
      dur_r[waddr] <= wdata;
    end
  end

  // Read port with same-cycle write forwarding.
  always_comb begin
    if (we && waddr_ok_s && (waddr == raddr)) begin
      rdata = wdata;
    end else if (raddr_ok_s) begin
      rdata = dur_r[raddr];
    end else begin
      rdata = LP_DEF;
    end
  end

endmodule

// File: rtl/light_phase_sequencer.sv
// Cyclic light phase sequencer: steps through P_NUM_PHASES phases, each
// lasting a programmable number of sec_tick pulses (zero counts as one).
// Optional feature macro LIGHT_PHASE_HOLD_EN adds a 'hold' input that
// parks the sequencer at the end of the current phase.
module light_phase_sequencer
  import light_pkg::*;
#(
  parameter int P_NUM_PHASES = 4,
  parameter int P_CNT_W      = 8,
  parameter int P_DEF_DUR    = 15,
  parameter int P_IDX_W      = $clog2(P_NUM_PHASES)
) (
  input  logic               clk,
  input  logic               rstb,
`ifdef LIGHT_PHASE_HOLD_EN
  input  logic               hold,
`endif
  input  logic               en,
  input  logic               sec_tick,
  input  logic               cfg_we,
  input  logic [P_IDX_W-1:0] cfg_addr,
  input  logic [P_CNT_W-1:0] cfg_data,
  input  logic               force_req,
  input  logic [P_IDX_W-1:0] force_idx,
  output logic [P_IDX_W-1:0] phase_idx,
  output logic [P_CNT_W-1:0] cnt_out,
  output logic               phase_tick,
  output logic               cycle_tick,
  output logic               cfg_err
);

  localparam logic [P_IDX_W:0]   LP_NUM     = P_NUM_PHASES[P_IDX_W:0];
  localparam logic [P_IDX_W-1:0] LP_LAST    = P_IDX_W'(P_NUM_PHASES - 1);
  localparam logic [P_IDX_W-1:0] LP_FIRST   = P_IDX_W'(PH_NS_GREEN);
  localparam logic [P_CNT_W-1:0] LP_RST_CNT = P_CNT_W'(P_DEF_DUR - 1);

  logic [P_IDX_W-1:0] phase_idx_r;
  logic [P_CNT_W-1:0] cnt_r;
  logic               phase_tick_r;
  logic               cycle_tick_r;
  logic               cfg_err_r;

  logic [P_IDX_W-1:0] next_idx_s;
  logic [P_IDX_W-1:0] rd_addr_s;
  logic [P_CNT_W-1:0] rd_dur_s;
  logic [P_CNT_W-1:0] load_cnt_s;
  logic               wrap_s;
  logic               hold_s;
  logic               force_ok_s;
  logic               force_go_s;
  logic               force_bad_s;
  logic               adv_s;
  logic               dec_s;
  logic               wr_err_s;

  // Countdown start for a duration: zero-length phases still last one tick.
  function automatic logic [P_CNT_W-1:0] load_val(input logic [P_CNT_W-1:0] d);
    if (d == {P_CNT_W{1'b0}}) begin
      return {P_CNT_W{1'b0}};
    end else begin
      return d - P_CNT_W'(1);
    end
  endfunction

  // Hold input exists only in the hold-capable build.
  always_comb begin
`ifdef LIGHT_PHASE_HOLD_EN
    hold_s = hold;
`else
    hold_s = 1'b0;
`endif
  end

  // Next-phase selection, event qualification and duration lookup address.
  always_comb begin
    wrap_s = (phase_idx_r == LP_LAST);
    if (wrap_s) begin
      next_idx_s = {P_IDX_W{1'b0}};
    end else begin
      next_idx_s = phase_idx_r + P_IDX_W'(1);
    end
    force_ok_s  = ({1'b0, force_idx} < LP_NUM);
    force_go_s  = en & force_req & force_ok_s;
    force_bad_s = en & force_req & ~force_ok_s;
    adv_s       = en & sec_tick & (cnt_r == {P_CNT_W{1'b0}}) & ~hold_s;
    dec_s       = en & sec_tick & (cnt_r != {P_CNT_W{1'b0}});
    if (force_go_s) begin
      rd_addr_s = force_idx;
    end else begin
      rd_addr_s = next_idx_s;
    end
    load_cnt_s = load_val(rd_dur_s);
  end

  light_dur_regfile #(
    .P_NUM_PHASES (P_NUM_PHASES),
    .P_CNT_W      (P_CNT_W),
    .P_DEF_DUR    (P_DEF_DUR),
    .P_IDX_W      (P_IDX_W)
  ) u_dur (
    .clk    (clk),
    .rstb   (rstb),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wdata  (cfg_data),
    .raddr  (rd_addr_s),
    .rdata  (rd_dur_s),
    .wr_err (wr_err_s)
  );

  // Phase/countdown state and event pulses; force wins over a normal advance.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      phase_idx_r  <= LP_FIRST;
      cnt_r        <= LP_RST_CNT;
      phase_tick_r <= 1'b0;
      cycle_tick_r <= 1'b0;
    end else if (force_go_s) begin
      phase_idx_r  <= force_idx;
      cnt_r        <= load_cnt_s;
      phase_tick_r <= 1'b1;
      cycle_tick_r <= 1'b0;
    end else if (adv_s) begin
      phase_idx_r  <= next_idx_s;
      cnt_r        <= load_cnt_s;
      phase_tick_r <= 1'b1;
      cycle_tick_r <= wrap_s;
    end else begin
      if (dec_s) begin
        cnt_r <= cnt_r - P_CNT_W'(1);
      end
      phase_tick_r <= 1'b0;
      cycle_tick_r <= 1'b0;
    end
  end

  // Sticky error flag for rejected writes and force requests.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_err_r | wr_err_s | force_bad_s;
    end
  end

  assign phase_idx  = phase_idx_r;
  assign cnt_out    = cnt_r;
  assign phase_tick = phase_tick_r;
  assign cycle_tick = cycle_tick_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Scoreboard bench for light_phase_sequencer: expected phase-change events
// are queued by the stimulus, a monitor pops one per observed pulse.
module tb_light_phase_sequencer;
  import light_pkg::*;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] cnt;
    logic       cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       en = 1'b0;
  logic       sec_tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       force_req = 1'b0;
  logic [1:0] force_idx = 2'd0;
  logic [1:0] phase_idx;
  logic [7:0] cnt_out;
  logic       phase_tick;
  logic       cycle_tick;
  logic       cfg_err;

  // Second instance with three phases, so an out-of-range index fits the port.
  logic       e_we = 1'b0;
  logic [1:0] e_addr = 2'd0;
  logic       e_force = 1'b0;
  logic [1:0] e_fidx = 2'd0;
  logic [1:0] e_phase;
  logic [7:0] e_cnt;
  logic       e_pt;
  logic       e_ct;
  logic       e_err;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulse_cnt = 0;
  int   cyc_cnt = 0;
  int   pulses_before;

  always #5 clk = ~clk;

  light_phase_sequencer dut (
    .clk        (clk),
    .rstb       (rstb),
`ifdef LIGHT_PHASE_HOLD_EN
    .hold       (1'b0),
`endif
    .en         (en),
    .sec_tick   (sec_tick),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .force_req  (force_req),
    .force_idx  (force_idx),
    .phase_idx  (phase_idx),
    .cnt_out    (cnt_out),
    .phase_tick (phase_tick),
    .cycle_tick (cycle_tick),
    .cfg_err    (cfg_err)
  );

  light_phase_sequencer #(.P_NUM_PHASES(3)) dut_e (
    .clk        (clk),
    .rstb       (rstb),
`ifdef LIGHT_PHASE_HOLD_EN
    .hold       (1'b0),
`endif
    .en         (en),
    .sec_tick   (sec_tick),
    .cfg_we     (e_we),
    .cfg_addr   (e_addr),
    .cfg_data   (8'd5),
    .force_req  (e_force),
    .force_idx  (e_fidx),
    .phase_idx  (e_phase),
    .cnt_out    (e_cnt),
    .phase_tick (e_pt),
    .cycle_tick (e_ct),
    .cfg_err    (e_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int cnt, input int cyc);
    exp_t e;
    e.idx = idx[1:0];
    e.cnt = cnt[7:0];
    e.cyc = cyc[0];
    sb_q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstb && (phase_tick || cycle_tick)) begin
      exp_t e;
      pulse_cnt++;
      if (cycle_tick) cyc_cnt++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: idx=%0d cnt=%0d pt=%0d ct=%0d", phase_idx, cnt_out, phase_tick, cycle_tick);
      end else begin
        e = sb_q.pop_front();
        if (phase_idx !== e.idx || cnt_out !== e.cnt || phase_tick !== 1'b1 || cycle_tick !== e.cyc) begin
          n_err++;
          $display("FAIL phase_event: got idx=%0d cnt=%0d pt=%0d ct=%0d expected idx=%0d cnt=%0d pt=1 ct=%0d",
                   phase_idx, cnt_out, phase_tick, cycle_tick, e.idx, e.cnt, e.cyc);
        end
      end
    end
  end

  // One sec_tick per 10 clocks.
  task automatic sec_n(input int n);
    repeat (n) begin
      @(negedge clk); sec_tick = 1'b1;
      @(negedge clk); sec_tick = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = addr[1:0]; cfg_data = data[7:0];
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic sec_wr(input int addr, input int data);
    @(negedge clk); sec_tick = 1'b1; cfg_we = 1'b1; cfg_addr = addr[1:0]; cfg_data = data[7:0];
    @(negedge clk); sec_tick = 1'b0; cfg_we = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic sec_force(input int idx);
    @(negedge clk); sec_tick = 1'b1; force_req = 1'b1; force_idx = idx[1:0];
    @(negedge clk); sec_tick = 1'b0; force_req = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #23;
    chk("rst_phase", phase_idx, 0);
    chk("rst_cnt", cnt_out, 14);
    chk("rst_ptick", phase_tick, 0);
    chk("rst_ctick", cycle_tick, 0);
    chk("rst_err", cfg_err, 0);
    @(negedge clk); rstb = 1'b1;
    en = 1'b1;
    cfg_write(PH_NS_GREEN, DUR_NS_GREEN);
    cfg_write(PH_NS_YELLOW, DUR_NS_YELLOW);
    cfg_write(PH_EW_GREEN, DUR_EW_GREEN);
    cfg_write(PH_EW_YELLOW, DUR_EW_YELLOW);
    chk("cfg_no_disturb", cnt_out, 14);

    // Full cycle 15/3/15/3.
    sec_n(1);  chk("cnt_first_dec", cnt_out, 13);
    sec_n(13); chk("cnt_p0_end", cnt_out, 0); chk("idx_p0_end", phase_idx, 0);
    push(1, 2, 0);  sec_n(1);
    sec_n(2);  chk("cnt_p1_end", cnt_out, 0);
    push(2, 14, 0); sec_n(1);
    sec_n(14);
    push(3, 2, 0);  sec_n(1);
    sec_n(2);
    push(0, 14, 1); sec_n(1);
    chk("pulses_cycle1", pulse_cnt, 4);
    chk("cycles_cycle1", cyc_cnt, 1);

    // Zero duration on phase 1, mid-phase rewrite of phase 0, bypassed write.
    cfg_write(1, 0);
    sec_n(9); chk("cnt_at5", cnt_out, 5);
    cfg_write(0, 7);
    chk("cnt_after_wr", cnt_out, 5);
    chk("idx_after_wr", phase_idx, 0);
    sec_n(5);
    push(1, 0, 0);  sec_n(1);
    push(2, 8, 0);  sec_wr(2, 9);
    sec_n(8);
    push(3, 2, 0);  sec_n(1);
    sec_n(2);
    push(0, 6, 1);  sec_n(1);
    chk("cycles_cycle2", cyc_cnt, 2);

    // Force coincident with an advance.
    sec_n(6); chk("cnt_before_force", cnt_out, 0);
    push(3, 2, 0);  sec_force(3);
    chk("err_after_force", cfg_err, 0);
    sec_n(2);
    push(0, 6, 1);  sec_n(1);
    sec_n(6);
    push(1, 0, 0);  sec_n(1);
    push(2, 8, 0);  sec_n(1);
    sec_n(3); chk("cnt_mid_p2", cnt_out, 5);

    // Disabled: ticks and force ignored.
    pulses_before = pulse_cnt;
    en = 1'b0; force_req = 1'b1; force_idx = 2'd1;
    sec_n(20);
    force_req = 1'b0;
    chk("frozen_idx", phase_idx, 2);
    chk("frozen_cnt", cnt_out, 5);
    chk("frozen_pulses", pulse_cnt, pulses_before);
    en = 1'b1;

    // Asynchronous reset mid-phase.
    @(negedge clk); #2 rstb = 1'b0;
    #1;
    chk("arst_idx", phase_idx, 0);
    chk("arst_cnt", cnt_out, 14);
    chk("arst_ptick", phase_tick, 0);
    @(negedge clk); rstb = 1'b1;
    sec_n(14);
    push(1, 14, 0); sec_n(1);

    // Out-of-range force on the three-phase instance.
    chk("e_err_clear", e_err, 0);
    @(negedge clk); e_force = 1'b1; e_fidx = 2'd3;
    @(negedge clk); e_force = 1'b0;
    chk("e_force_err", e_err, 1);
    chk("e_force_idx", e_phase, 1);
    chk("e_force_cnt", e_cnt, 14);
    chk("e_force_pt", e_pt, 0);
    chk("e_force_ct", e_ct, 0);
    repeat (3) @(negedge clk);
    chk("e_err_sticky", e_err, 1);

    // Out-of-range write on the three-phase instance.
    @(negedge clk); rstb = 1'b0;
    @(negedge clk); rstb = 1'b1;
    chk("e_err_rst", e_err, 0);
    @(negedge clk); e_we = 1'b1; e_addr = 2'd3;
    @(negedge clk); e_we = 1'b0;
    chk("e_wr_err", e_err, 1);
    chk("main_err_clean", cfg_err, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
